// File: rtl/spi_master_tx_fifo.sv
// Purpose: TX word FIFO feeding the SPI shifter from the register/APB side; any depth >= 2.
// Latency: 1 cycle push-to-head (no fall-through); pop takes effect on the accepting edge.
// Backpressure: ready_o drops when full (no push even with a same-cycle pop); valid_o drops when empty.
//
// Ports:
//   clk, rst           sole clock; synchronous active-high reset
//   clr_i              synchronous soft clear, empties the FIFO
//   elements_o         occupancy, 0..BUFFER_DEPTH
//   data_i/valid_i/ready_o   write side
//   data_o/valid_o/ready_i   read side (head word to the TX shifter)
module spi_master_tx_fifo #(
    parameter int DATA_WIDTH       = 32,
    parameter int BUFFER_DEPTH     = 8,
    parameter int LOG_BUFFER_DEPTH = $clog2(BUFFER_DEPTH)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_i,
    output logic [LOG_BUFFER_DEPTH:0]   elements_o,
    input  logic [DATA_WIDTH-1:0]       data_i,
    input  logic                        valid_i,
    output logic                        ready_o,
    output logic [DATA_WIDTH-1:0]       data_o,
    output logic                        valid_o,
    input  logic                        ready_i
);

    localparam int                        LAST_IDX   = BUFFER_DEPTH - 1;
    localparam logic [LOG_BUFFER_DEPTH-1:0] LAST_PTR = LAST_IDX[LOG_BUFFER_DEPTH-1:0];
    localparam logic [LOG_BUFFER_DEPTH:0]   FULL_CNT = BUFFER_DEPTH[LOG_BUFFER_DEPTH:0];

    logic [DATA_WIDTH-1:0]       mem [BUFFER_DEPTH];
    logic [LOG_BUFFER_DEPTH-1:0] rd_ptr_q;
    logic [LOG_BUFFER_DEPTH-1:0] wr_ptr_q;
    logic [LOG_BUFFER_DEPTH:0]   count_q;

    logic push;
    logic pop;
    logic [LOG_BUFFER_DEPTH-1:0] rd_ptr_nxt;
    logic [LOG_BUFFER_DEPTH-1:0] wr_ptr_nxt;

    // Handshake flags come only from registered occupancy, so a full FIFO
    // refuses a push even when the shifter pops in the same cycle.
    assign ready_o    = (count_q != FULL_CNT);
    assign valid_o    = (count_q != '0);
    assign elements_o = count_q;
    assign data_o     = mem[rd_ptr_q];

    assign push = valid_i && ready_o;
    assign pop  = valid_o && ready_i;

    // Explicit compare-and-wrap so non-power-of-two depths never reach an
    // out-of-range index.
    always_comb begin
        rd_ptr_nxt = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        wr_ptr_nxt = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clr_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_nxt;
            if (pop)  rd_ptr_q <= rd_ptr_nxt;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; a cleared push is simply not written.
    always_ff @(posedge clk) begin
        if (push && !clr_i && !rst) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: tb/tb_spi_master_tx_fifo.sv
module tb_spi_master_tx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    // depth-8 instance
    logic        clr_i;
    logic [3:0]  elements_o;
    logic [31:0] data_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;
    // depth-5 instance
    logic        clr5;
    logic [3:0]  elem5;
    logic [31:0] din5;
    logic        vin5;
    logic        rdy_out5;
    logic [31:0] dout5;
    logic        vout5;
    logic        rdy_in5;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_master_tx_fifo u_dut (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_i),
        .elements_o (elements_o),
        .data_i     (data_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .data_o     (data_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
    );

    spi_master_tx_fifo #(.DATA_WIDTH(32), .BUFFER_DEPTH(5)) u_dut5 (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr5),
        .elements_o (elem5),
        .data_i     (din5),
        .valid_i    (vin5),
        .ready_o    (rdy_out5),
        .data_o     (dout5),
        .valid_o    (vout5),
        .ready_i    (rdy_in5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled and inputs changed 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; clr_i = 1'b0; data_i = '0; valid_i = 1'b0; ready_i = 1'b0;
        clr5 = 1'b0; din5 = '0; vin5 = 1'b0; rdy_in5 = 1'b0;
        step(); step();
        rst = 1'b0;

        // Reset state
        chk("reset_elements", 32'(elements_o), 32'd0);
        chk("reset_valid",    32'(valid_o),    32'd0);
        chk("reset_ready",    32'(ready_o),    32'd1);
        chk("reset5_ready",   32'(rdy_out5),   32'd1);

        // Single push, visible the cycle after
        data_i = 32'hA5A5_0001; valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        chk("single_valid", 32'(valid_o),    32'd1);
        chk("single_data",  data_o,          32'hA5A5_0001);
        chk("single_elem",  32'(elements_o), 32'd1);
        ready_i = 1'b1;
        step();
        ready_i = 1'b0;
        chk("single_pop_elem",  32'(elements_o), 32'd0);
        chk("single_pop_valid", 32'(valid_o),    32'd0);

        // Fill to full, refused 9th push, drain in order
        for (int i = 0; i < 8; i++) begin
            data_i = 32'(i); valid_i = 1'b1;
            step();
        end
        chk("full_elem",  32'(elements_o), 32'd8);
        chk("full_ready", 32'(ready_o),    32'd0);
        data_i = 32'hFF;
        step();
        valid_i = 1'b0;
        chk("overflow_elem", 32'(elements_o), 32'd8);
        chk("overflow_head", data_o,          32'd0);
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", 32'(valid_o), 32'd1);
            chk("drain_data",  data_o,       32'(i));
            step();
        end
        chk("drained_elem",  32'(elements_o), 32'd0);
        chk("drained_valid", 32'(valid_o),    32'd0);
        // ready_i held while empty is ignored
        step();
        ready_i = 1'b0;
        chk("empty_pop_elem",  32'(elements_o), 32'd0);
        chk("empty_pop_ready", 32'(ready_o),    32'd1);

        // Full with simultaneous push+pop: pop only
        for (int i = 0; i < 8; i++) begin
            data_i = 32'h10 + 32'(i); valid_i = 1'b1;
            step();
        end
        data_i = 32'hEE; valid_i = 1'b1; ready_i = 1'b1;
        step();
        valid_i = 1'b0; ready_i = 1'b0;
        chk("full_pushpop_elem", 32'(elements_o), 32'd7);
        chk("full_pushpop_head", data_o,          32'h11);
        ready_i = 1'b1;
        for (int i = 1; i < 8; i++) begin
            chk("full_pushpop_drain", data_o, 32'h10 + 32'(i));
            step();
        end
        ready_i = 1'b0;
        chk("full_pushpop_empty", 32'(valid_o), 32'd0);

        // Occupancy 3, 20 cycles of simultaneous push/pop across the wrap
        for (int i = 0; i < 3; i++) begin
            data_i = 32'h100 + 32'(i); valid_i = 1'b1;
            step();
        end
        ready_i = 1'b1;
        for (int k = 0; k < 20; k++) begin
            data_i = 32'h103 + 32'(k);
            chk("steady_head", data_o, 32'h100 + 32'(k));
            step();
            chk("steady_elem", 32'(elements_o), 32'd3);
        end
        valid_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("steady_tail", data_o, 32'h114 + 32'(i));
            step();
        end
        ready_i = 1'b0;
        chk("steady_empty", 32'(elements_o), 32'd0);

        // Clear with concurrent push/pop at occupancy 4
        for (int i = 0; i < 4; i++) begin
            data_i = 32'h200 + 32'(i); valid_i = 1'b1;
            step();
        end
        valid_i = 1'b0;
        chk("preclr_elem", 32'(elements_o), 32'd4);
        clr_i = 1'b1; valid_i = 1'b1; data_i = 32'h2FF; ready_i = 1'b1;
        step();
        clr_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
        chk("clr_elem",  32'(elements_o), 32'd0);
        chk("clr_valid", 32'(valid_o),    32'd0);
        chk("clr_ready", 32'(ready_o),    32'd1);
        data_i = 32'h300; valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        chk("post_clr_data", data_o,          32'h300);
        chk("post_clr_elem", 32'(elements_o), 32'd1);

        // Reset during a stream
        valid_i = 1'b1; ready_i = 1'b1; data_i = 32'h301;
        step();
        data_i = 32'h302; ready_i = 1'b0;
        step();
        rst = 1'b1; data_i = 32'h303;
        step();
        rst = 1'b0; valid_i = 1'b0;
        chk("rst_stream_elem",  32'(elements_o), 32'd0);
        chk("rst_stream_valid", 32'(valid_o),    32'd0);
        data_i = 32'h400; valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        chk("post_rst_data", data_o,          32'h400);
        chk("post_rst_elem", 32'(elements_o), 32'd1);

        // Depth 5: push-then-pop pairs across the 4 -> 0 wrap
        for (int k = 0; k < 12; k++) begin
            din5 = 32'h500 + 32'(k); vin5 = 1'b1;
            step();
            vin5 = 1'b0;
            chk("d5_pair_data", dout5, 32'h500 + 32'(k));
            rdy_in5 = 1'b1;
            step();
            rdy_in5 = 1'b0;
            chk("d5_pair_elem", 32'(elem5), 32'd0);
        end
        // Depth 5: fill, refuse, drain
        for (int i = 0; i < 6; i++) begin
            din5 = 32'h600 + 32'(i); vin5 = 1'b1;
            step();
        end
        vin5 = 1'b0;
        chk("d5_full_elem",  32'(elem5),    32'd5);
        chk("d5_full_ready", 32'(rdy_out5), 32'd0);
        rdy_in5 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("d5_drain", dout5, 32'h600 + 32'(i));
            step();
        end
        rdy_in5 = 1'b0;
        chk("d5_empty", 32'(vout5), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
